// File: rtl/sys_mem_port.sv
// System-side memory port: runs one strobed read/write against a synchronous SRAM macro with a WAIT_CYCLES wait window.
// Optional out-of-range address error response is enabled by defining SYS_ERR_EN.
module sys_mem_port #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MEM_WORDS   = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sys_strobe,
    input  logic              sys_rw,
    input  logic [ADDR_W-1:0] sys_addr,
    input  logic [DATA_W-1:0] sys_wdata,
    input  logic [3:0]        sys_be,
    output logic [DATA_W-1:0] sys_rdata,
    output logic              sys_ready,
    output logic              sys_busy,
    output logic              sys_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              armed;
    logic              rw_q;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              err_hit;
    logic              accept;

    // Byte offset is never used: all accesses are word-aligned.
    logic unused_byte_offset;
    assign unused_byte_offset = ^sys_addr[1:0];

`ifdef SYS_ERR_EN
    localparam logic [ADDR_W-3:0] MEM_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    assign err_hit = (sys_addr[ADDR_W-1:2] >= MEM_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= err_hit;
        end
    end
`else
    logic [31:0] unused_mem_words;
    assign unused_mem_words = 32'(MEM_WORDS);
    assign err_hit = 1'b0;
    assign err_q   = 1'b0;
`endif

    // armed stays low for the first edge after reset release so a strobe coincident with release is dropped.
    assign accept = (state == S_IDLE) && armed && sys_strobe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            armed   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) begin
                rw_q    <= sys_rw;
                addr_q  <= sys_addr[ADDR_W-1:2];
                wdata_q <= sys_wdata;
                be_q    <= sys_be;
            end
            if (state == S_SETUP) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if ((state == S_CAPTURE) && rw_q && !err_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = err_hit ? S_CAPTURE : S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = (WAIT_CYCLES == 0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_cs    = (state != S_IDLE) && !err_q;
        mem_we    = ((state == S_SETUP) || (state == S_WAIT)) && !rw_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_cs) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_be    = be_q;
        end
    end

    assign sys_ready = (state == S_CAPTURE);
    assign sys_err   = (state == S_CAPTURE) && err_q;
    assign sys_busy  = (state != S_IDLE);
    assign sys_rdata = rdata_q;

endmodule
